// File: rtl/hms_bcd_counter.sv
`timescale 1ns/1ps
// hms_bcd_counter: BCD time-of-day counter (hh:mm:ss) with a seconds prescaler,
// run/stop, and debounced clear / hour-set / minute-set pushbuttons.
// Optional feature macro: HMS_12H_EN selects the 12-hour build (01..12 with oPM).
// Without it the counter runs 00..23 and oPM is tied low.
module hms_bcd_counter #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       iCLK_50MHZ,
    input  logic       iRST_N,
    input  logic       iRUN,
    input  logic       iKEY_CLR_N,
    input  logic       iKEY_HR_N,
    input  logic       iKEY_MIN_N,
    output logic [3:0] oTensBin3,
    output logic [3:0] oOnesBin3,
    output logic [3:0] oTensBin2,
    output logic [3:0] oOnesBin2,
    output logic [3:0] oTensBin1,
    output logic [3:0] oOnesBin1,
    output logic       oPM,
    output logic       oTick
);

    localparam int              PW      = $clog2(CLK_HZ);
    localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_HZ - 1);
    localparam int              DEB_DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int              DW      = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [DW-1:0]   DEB_MAX = DW'(DEB_DIV - 1);
`ifdef HMS_12H_EN
    localparam logic [7:0]      HR_RESET = 8'h12;
`else
    localparam logic [7:0]      HR_RESET = 8'h00;
`endif
    // Key vector bit positions.
    localparam int K_CLR = 0;
    localparam int K_HR  = 1;
    localparam int K_MIN = 2;

    logic [PW-1:0]   pre_q, pre_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [7:0]      sec_q, sec_d;
    logic [7:0]      min_q, min_d;
    logic [7:0]      hr_q, hr_d;
    logic            tick_q, tick_d;
    logic [2:0]      sync1_q, sync1_d;
    logic [2:0]      sync2_q, sync2_d;
    logic [2:0][2:0] hist_q, hist_d;
    logic [2:0]      pressed_q, pressed_d;
    logic [2:0]      press_q, press_d;
`ifdef HMS_12H_EN
    logic            pm_q, pm_d;
`endif
    logic            strobe;
    logic            tick;
    logic            carry_min;
    logic            carry_hr;

    // BCD mod-60 increment of a {tens, ones} pair.
    function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] != 4'd9)      r = {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd5) r = {v[7:4] + 4'd1, 4'd0};
        else                     r = 8'h00;
        return r;
    endfunction

    // BCD hour increment following the configured hour sequence.
    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        logic [7:0] r;
`ifdef HMS_12H_EN
        if (v == 8'h12)          r = 8'h01;
`else
        if (v == 8'h23)          r = 8'h00;
`endif
        else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
        else                     r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Key synchronizers, 1 kHz debounce strobe and 4-sample stable filter.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        sync1_d   = {iKEY_MIN_N, iKEY_HR_N, iKEY_CLR_N};
        sync2_d   = sync1_q;
        strobe    = (deb_cnt_q == DEB_MAX);
        deb_cnt_d = strobe ? '0 : deb_cnt_q + DW'(1);
        hist_d    = hist_q;
        pressed_d = pressed_q;
        press_d   = '0;
        for (int i = 0; i < 3; i++) begin
            if (strobe) begin
                hist_d[i] = {hist_q[i][1:0], sync2_q[i]};
                // Current sample plus the three held ones: four consecutive samples.
                if (!sync2_q[i] && hist_q[i] == 3'b000) begin
                    pressed_d[i] = 1'b1;
                    press_d[i]   = !pressed_q[i];
                end else if (sync2_q[i] && hist_q[i] == 3'b111) begin
                    pressed_d[i] = 1'b0;
                end
            end
        end
    end

    // Prescaler, BCD carry chain and set keys; CLR over set keys over tick carry.
    always_comb begin
        pre_d     = pre_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hr_d      = hr_q;
        tick_d    = 1'b0;
        carry_min = 1'b0;
        carry_hr  = 1'b0;
`ifdef HMS_12H_EN
        pm_d      = pm_q;
`endif
        tick = iRUN && (pre_q == PRE_MAX);
        if (iRUN) pre_d = tick ? '0 : pre_q + PW'(1);

        if (tick) begin
            sec_d     = inc_bcd60(sec_q);
            carry_min = (sec_q == 8'h59);
            tick_d    = 1'b1;
        end

        // A minute set absorbs any carry arriving from seconds in the same cycle.
        if (press_q[K_MIN]) begin
            min_d = inc_bcd60(min_q);
        end else if (carry_min) begin
            min_d    = inc_bcd60(min_q);
            carry_hr = (min_q == 8'h59);
        end

        // An hour set and a carry into hours together still advance hours once.
        if (press_q[K_HR] || carry_hr) begin
            hr_d = inc_hours(hr_q);
`ifdef HMS_12H_EN
            if (hr_q == 8'h11) pm_d = !pm_q;
`endif
        end

        if (press_q[K_CLR]) begin
            pre_d  = '0;
            sec_d  = 8'h00;
            min_d  = 8'h00;
            hr_d   = HR_RESET;
            tick_d = 1'b0;
`ifdef HMS_12H_EN
            pm_d   = 1'b0;
`endif
        end
    end

    // State registers; keys reset to the released level.
    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            pre_q     <= '0;
            deb_cnt_q <= '0;
            sec_q     <= 8'h00;
            min_q     <= 8'h00;
            hr_q      <= HR_RESET;
            tick_q    <= 1'b0;
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            hist_q    <= '1;
            pressed_q <= '0;
            press_q   <= '0;
`ifdef HMS_12H_EN
            pm_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            pre_q     <= pre_d;
            deb_cnt_q <= deb_cnt_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            hr_q      <= hr_d;
            tick_q    <= tick_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
`ifdef HMS_12H_EN
            pm_q      <= pm_d;
`endif
        end
    end

    assign oTensBin3 = hr_q[7:4];
    assign oOnesBin3 = hr_q[3:0];
    assign oTensBin2 = min_q[7:4];
    assign oOnesBin2 = min_q[3:0];
    assign oTensBin1 = sec_q[7:4];
    assign oOnesBin1 = sec_q[3:0];
    assign oTick     = tick_q;
`ifdef HMS_12H_EN
    assign oPM       = pm_q;
`else
    assign oPM       = 1'b0;
`endif

endmodule
